// File: rtl/data_sram_bridge.sv
// Bridges the M-stage memory port onto an SRAM-like request/response bus.
// Exactly one request per memory instruction; the result is held while the pipeline is stalled elsewhere.
module data_sram_bridge #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_en,
  input  logic [3:0]        mem_wen,
  input  logic [1:0]        mem_size,
  input  logic [31:0]       mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              stall_other,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_stall,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [3:0]        data_wstrb,
  output logic [31:0]       data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state;
  state_t            stateNext;
  logic [31:0]       reqAddr;
  logic [DATA_W-1:0] reqWdata;
  logic [1:0]        reqSize;
  logic [3:0]        reqWstrb;
  logic [DATA_W-1:0] rdataBuf;
  logic              dataDone;

  assign dataDone = (state == DATA) && data_data_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // addr_ok only matters in IDLE/ADDR and data_ok only in DATA; everything else holds.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (mem_en) begin
          stateNext = data_addr_ok ? DATA : ADDR;
        end
      end
      ADDR: begin
        if (data_addr_ok) begin
          stateNext = DATA;
        end
      end
      DATA: begin
        if (data_data_ok) begin
          stateNext = stall_other ? DONE : IDLE;
        end
      end
      DONE: begin
        if (!stall_other) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Request fields are sampled every IDLE cycle so ADDR replays exactly what was first offered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reqAddr  <= '0;
      reqWdata <= '0;
      reqSize  <= '0;
      reqWstrb <= '0;
    end else if (state == IDLE) begin
      reqAddr  <= mem_addr;
      reqWdata <= mem_wdata;
      reqSize  <= mem_size;
      reqWstrb <= mem_wen;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdataBuf <= '0;
    end else if (dataDone && (reqWstrb == 4'b0000)) begin
      rdataBuf <= data_rdata;
    end
  end

  always_comb begin
    if (state == IDLE) begin
      data_addr  = mem_addr;
      data_wdata = mem_wdata;
      data_size  = mem_size;
      data_wstrb = mem_wen;
    end else begin
      data_addr  = reqAddr;
      data_wdata = reqWdata;
      data_size  = reqSize;
      data_wstrb = reqWstrb;
    end
  end

  assign data_wr   = |data_wstrb;
  // Gated by rst so nothing is offered while reset holds the FSM in IDLE.
  assign data_req  = rst && (((state == IDLE) && mem_en) || (state == ADDR));
  assign mem_stall = mem_en && (state != DONE) && !dataDone;
  assign mem_rdata = dataDone ? data_rdata : rdataBuf;

endmodule

// File: tb/tb_data_sram_bridge.sv
// Randomized scoreboard bench for data_sram_bridge: the driver queues expected requests,
// stall lengths and load results per instruction; a negedge monitor pops and compares.
module tb_data_sram_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        stall_other;
  logic [31:0] mem_rdata;
  logic        mem_stall;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  always #5 clk = ~clk;

  data_sram_bridge #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .stall_other(stall_other),
    .mem_rdata(mem_rdata), .mem_stall(mem_stall),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic        wr;
    logic [7:0]  nCyc;
  } reqExp_t;

  typedef struct packed {
    logic        isLoad;
    logic [31:0] rdata;
  } loadExp_t;

  reqExp_t     reqQ[$];
  int          stallQ[$];
  loadExp_t    loadQ[$];
  logic [31:0] expBuf;
  int          checks = 0;
  int          failures = 0;
  int          nIssued = 0;
  int          nHandshake = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic noteEmpty(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=empty-queue required=pending-entry t=%0t", name, $time);
  endtask

  // Monitor: samples on the falling edge, away from the driver's updates.
  initial begin : monitor
    int       reqCyc;
    int       stallCnt;
    bit       busy;
    bit       pendRetire;
    reqExp_t  e;
    loadExp_t le;
    reqCyc = 0; stallCnt = 0; busy = 0; pendRetire = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        reqCyc = 0; stallCnt = 0; busy = 0; pendRetire = 0;
        check("rst_data_req", data_req, 1'b0);
        check("rst_mem_stall", mem_stall, mem_en);
      end else begin
        if (data_req) begin
          if (reqQ.size() == 0) begin
            noteEmpty("req_unexpected");
          end else begin
            e = reqQ[0];
            reqCyc++;
            check("req_fields", {data_addr, data_wdata, data_size, data_wstrb, data_wr},
                  {e.addr, e.wdata, e.size, e.wstrb, e.wr});
            if (data_addr_ok) begin
              check("req_len", reqCyc, e.nCyc);
              void'(reqQ.pop_front());
              reqCyc = 0;
              nHandshake++;
            end
          end
        end
        if (mem_en && mem_stall) begin
          busy = 1;
          stallCnt++;
        end else if (mem_en && busy) begin
          if (stallQ.size() == 0) noteEmpty("stall_unexpected");
          else check("stall_len", stallCnt, stallQ.pop_front());
          busy = 0;
          stallCnt = 0;
          pendRetire = 1;
        end
        if (pendRetire && mem_en && !mem_stall) begin
          if (loadQ.size() == 0) begin
            noteEmpty("retire_unexpected");
            pendRetire = 0;
          end else begin
            le = loadQ[0];
            if (le.isLoad) check("load_rdata", mem_rdata, le.rdata);
            if (!stall_other) begin
              void'(loadQ.pop_front());
              pendRetire = 0;
            end
          end
        end else if (!mem_en && !busy && !pendRetire) begin
          check("idle_rdata", mem_rdata, expBuf);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strays();
    data_addr_ok = 1'($urandom_range(0, 1));
    data_data_ok = 1'($urandom_range(0, 1));
    data_rdata   = $urandom;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      mem_en      = 1'b0;
      mem_wen     = 4'($urandom);
      mem_size    = 2'($urandom);
      mem_addr    = $urandom;
      mem_wdata   = $urandom;
      stall_other = 1'($urandom_range(0, 1));
      strays();
      tick();
    end
  endtask

  // One memory instruction: addr_ok after da wait cycles, data_ok after dd more,
  // stall_other high for s cycles starting at the data_ok cycle.
  task automatic doTxn(input logic [3:0] wen, input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata,
                       input int da, input int dd, input int s);
    reqExp_t  e;
    loadExp_t le;
    e.addr = addr; e.wdata = wdata; e.size = size; e.wstrb = wen; e.wr = (wen != 4'b0000);
    e.nCyc = 8'(da + 1);
    reqQ.push_back(e);
    stallQ.push_back(da + dd + 1);
    le.isLoad = (wen == 4'b0000);
    le.rdata  = rdata;
    loadQ.push_back(le);
    nIssued++;
    mem_en = 1'b1; mem_wen = wen; mem_size = size; mem_addr = addr; mem_wdata = wdata;
    for (int c = 0; c <= da; c++) begin
      strays();
      data_addr_ok = (c == da);
      stall_other  = 1'($urandom_range(0, 1));
      tick();
    end
    for (int c = 0; c < dd; c++) begin
      strays();
      data_data_ok = 1'b0;
      stall_other  = 1'($urandom_range(0, 1));
      tick();
    end
    data_addr_ok = 1'($urandom_range(0, 1));
    data_data_ok = 1'b1;
    data_rdata   = rdata;
    stall_other  = (s > 0);
    if (wen == 4'b0000) expBuf = rdata;
    tick();
    if (s > 0) begin
      for (int c = 1; c < s; c++) begin
        strays();
        stall_other = 1'b1;
        tick();
      end
      strays();
      stall_other = 1'b0;
      tick();
    end
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
  endtask

  task automatic resetMidData();
    reqExp_t  e;
    loadExp_t le;
    e.addr = 32'h8000_0040; e.wdata = 32'h0; e.size = 2'd2; e.wstrb = 4'b0000; e.wr = 1'b0; e.nCyc = 8'd1;
    reqQ.push_back(e);
    stallQ.push_back(2);
    le.isLoad = 1'b1; le.rdata = 32'h0;
    loadQ.push_back(le);
    nIssued++;
    mem_en = 1'b1; mem_wen = 4'b0000; mem_size = 2'd2; mem_addr = 32'h8000_0040; mem_wdata = 32'h0;
    data_addr_ok = 1'b1; data_data_ok = 1'b0; stall_other = 1'b0;
    tick();
    data_addr_ok = 1'b0;
    rst = 1'b0;
    #1;
    check("rstmid_data_req", data_req, 1'b0);
    check("rstmid_mem_stall", mem_stall, 1'b1);
    check("rstmid_mem_rdata", mem_rdata, 32'h0);
    reqQ.delete();
    stallQ.delete();
    loadQ.delete();
    expBuf = 32'h0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(2);
    doTxn(4'b0000, 2'd2, 32'h8000_0044, 32'h0, 32'h5A5A_1234, 0, 1, 0);
  endtask

  initial begin : driver
    logic [31:0] a;
    logic [1:0]  sz;
    logic [3:0]  wen;
    rst = 1'b0; mem_en = 1'b0; mem_wen = 4'h0; mem_size = 2'd0; mem_addr = 32'h0; mem_wdata = 32'h0;
    stall_other = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
    expBuf = 32'h0;
    #2;
    check("init_data_req", data_req, 1'b0);
    check("init_mem_stall", mem_stall, 1'b0);
    check("init_mem_rdata", mem_rdata, 32'h0);
    mem_en = 1'b1;
    #1;
    check("init_req_en", data_req, 1'b0);
    check("init_stall_en", mem_stall, 1'b1);
    tick();
    rst = 1'b1;
    mem_en = 1'b0;
    idle(2);

    doTxn(4'b0000, 2'd2, 32'h8000_0010, 32'h1111_2222, 32'hDEAD_BEEF, 0, 0, 0);
    idle(2);
    doTxn(4'b0100, 2'd0, 32'h8000_0002, 32'h00AB_0000, 32'h7777_7777, 3, 0, 0);
    idle(2);
    doTxn(4'b0000, 2'd2, 32'h8000_0020, 32'h0, 32'h1234_5678, 0, 1, 5);
    idle(1);
    doTxn(4'b0000, 2'd1, 32'h8000_0032, 32'h0, 32'hCAFE_F00D, 2, 3, 0);
    idle(3);
    doTxn(4'b0000, 2'd2, 32'h8000_0100, 32'h0, 32'h0BAD_CAFE, 0, 0, 0);
    doTxn(4'b1111, 2'd2, 32'h8000_0104, 32'hFEED_FACE, 32'h9999_9999, 0, 0, 0);
    idle(2);
    resetMidData();
    idle(2);

    for (int i = 0; i < 60; i++) begin
      a  = $urandom;
      sz = 2'($urandom_range(0, 2));
      case (sz)
        2'd0:    wen = 4'b0001 << a[1:0];
        2'd1:    wen = a[1] ? 4'b1100 : 4'b0011;
        default: wen = 4'b1111;
      endcase
      if ($urandom_range(0, 1) == 0) wen = 4'b0000;
      doTxn(wen, sz, a, $urandom, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0);
      idle(int'($urandom_range(0, 2)));
    end

    idle(3);
    check("left_req", reqQ.size(), 0);
    check("left_stall", stallQ.size(), 0);
    check("left_load", loadQ.size(), 0);
    check("handshake_total", nHandshake, nIssued);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
